// File: rtl/tsc_capture_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// tsc_pkg
// Shared definitions for the trigger-surround capture controller: FSM state
// encoding (also exported on the debug state port) and default geometry.
// -----------------------------------------------------------------------------
package tsc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_RUN  = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4,
    ST_SEND = 3'd5
  } tsc_state_e;

  localparam int unsigned DW_DEF     = 8;
  localparam int unsigned DEPTH_DEF  = 32;
  localparam int unsigned PRE_DEF    = 16;
  localparam logic [7:0]  TRIGVL_DEF = 8'hD5;

endpackage

// File: rtl/tsc_capture_ctrl_if.sv
// -----------------------------------------------------------------------------
// tsc_capture_ctrl_if
// 4-phase req/rdy sample handshake between the capture controller (master)
// and the ADC (slave).
//   req  master->slave  request a sample
//   rdy  slave->master  sample valid / acknowledge
//   dat  slave->master  sample, valid while rdy=1
// -----------------------------------------------------------------------------
interface tsc_capture_ctrl_if
  import tsc_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
);
  logic          req;
  logic          rdy;
  logic [DW-1:0] dat;

  modport master (output req, input rdy, input dat);
  modport slave  (input req, output rdy, output dat);
endinterface

// File: rtl/tsc_capture_ctrl_ring_ram.sv
// -----------------------------------------------------------------------------
// tsc_ring_ram
// DEPTH x DW sample ring. Synchronous write, combinational read, no reset
// (contents are always fully rewritten by a capture before being read).
//   clk    in  write clock
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write data
//   raddr  in  read address
//   rdata  out read data (combinational)
// -----------------------------------------------------------------------------
module tsc_ring_ram #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 32,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tsc_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tsc_capture_ctrl
// Capture sequencer for the trigger-surround cache. Pulls samples from the ADC
// over a 4-phase handshake into a ring, detects the trigger, freezes a window
// of PRE samples before and DEPTH-PRE-1 after the trigger sample, and on
// request shifts the window out serially (oldest sample first, MSB first).
//   clk     in   system clock
//   reset   in   async active-low reset
//   start   in   begin a capture (IDLE/DONE only)
//   sbf     in   send the frozen window (DONE only, wins over start)
//   adc     if   master side of the ADC handshake
//   trd     out  trigger detected (level, cleared on next ARM)
//   trigtm  out  free-running timer value at the trigger accept edge
//   sd      out  serial data
//   cd      out  one-cycle transfer-complete pulse
//   state   out  FSM state (debug)
//
// state | meaning
// IDLE  | waiting for start
// ARM   | filling PRE pre-trigger samples, trigger ignored
// RUN   | sampling, looking for sample >= TRIGVL
// POST  | collecting DEPTH-PRE-1 post-trigger samples
// DONE  | ring frozen, oldest sample at wr_ptr
// SEND  | shifting DEPTH*DW bits out on sd
// -----------------------------------------------------------------------------
module tsc_capture_ctrl
  import tsc_pkg::*;
#(
  parameter int unsigned   DW     = DW_DEF,
  parameter int unsigned   DEPTH  = DEPTH_DEF,
  parameter int unsigned   PRE    = PRE_DEF,
  parameter logic [DW-1:0] TRIGVL = DW'(TRIGVL_DEF)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        sbf,
  tsc_capture_ctrl_if.master adc,
  output logic        trd,
  output logic [31:0] trigtm,
  output logic        sd,
  output logic        cd,
  output logic [2:0]  state
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned BW     = (DW > 1) ? $clog2(DW) : 1;
  localparam int unsigned CW     = $clog2(DEPTH * DW);
  localparam int unsigned POST_N = DEPTH - PRE - 1;

  tsc_state_e    st_q;
  logic [31:0]   timer_q;
  logic          req_q;
  logic          hs_wait;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] pre_cnt;
  logic [AW-1:0] post_cnt;
  logic [CW-1:0] bit_cnt;
  logic [BW-1:0] bit_idx;
  logic [DW-1:0] shreg;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          accept;
  logic          capturing;

  assign adc.req   = req_q;
  assign state     = st_q;
  // req_q is only ever high in ARM/RUN/POST, so rdy outside those is ignored.
  assign accept    = req_q & adc.rdy;
  assign capturing = (st_q == ST_ARM) || (st_q == ST_RUN) || (st_q == ST_POST);
  // DONE reads the oldest sample to preload the shifter; SEND walks forward.
  assign rd_addr   = (st_q == ST_SEND) ? rd_ptr : wr_ptr;

  tsc_ring_ram #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_ring (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_ptr),
    .wdata (adc.dat),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) timer_q <= '0;
    else        timer_q <= timer_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q     <= ST_IDLE;
      req_q    <= 1'b0;
      hs_wait  <= 1'b0;
      trd      <= 1'b0;
      trigtm   <= '0;
      sd       <= 1'b0;
      cd       <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pre_cnt  <= '0;
      post_cnt <= '0;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      cd <= 1'b0;

      if (accept) wr_ptr <= wr_ptr + AW'(1);

      // Drop req on the accept edge; re-raise on the edge that sees rdy low.
      if (accept) begin
        req_q   <= 1'b0;
        hs_wait <= 1'b1;
      end else if (capturing && hs_wait && !adc.rdy) begin
        req_q   <= 1'b1;
        hs_wait <= 1'b0;
      end

      unique case (st_q)
        ST_IDLE: begin
          if (start) begin
            st_q    <= ST_ARM;
            trd     <= 1'b0;
            pre_cnt <= '0;
            // If the ADC is still holding rdy, wait for it to drop first.
            req_q   <= !adc.rdy;
            hs_wait <= adc.rdy;
          end
        end

        ST_ARM: begin
          if (accept) begin
            pre_cnt <= pre_cnt + AW'(1);
            if (pre_cnt == AW'(PRE - 1)) st_q <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (accept && (adc.dat >= TRIGVL)) begin
            trd      <= 1'b1;
            trigtm   <= timer_q;
            post_cnt <= AW'(POST_N);
            st_q     <= (POST_N == 0) ? ST_DONE : ST_POST;
          end
        end

        ST_POST: begin
          if (accept) begin
            post_cnt <= post_cnt - AW'(1);
            if (post_cnt == AW'(1)) st_q <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (sbf) begin
            st_q    <= ST_SEND;
            shreg   <= rd_data;
            sd      <= rd_data[DW-1];
            rd_ptr  <= wr_ptr + AW'(1);
            bit_idx <= '0;
            bit_cnt <= CW'(DEPTH * DW - 1);
          end else if (start) begin
            st_q    <= ST_ARM;
            trd     <= 1'b0;
            pre_cnt <= '0;
            req_q   <= !adc.rdy;
            hs_wait <= adc.rdy;
          end
        end

        ST_SEND: begin
          if (bit_cnt == '0) begin
            sd   <= 1'b0;
            cd   <= 1'b1;
            st_q <= ST_IDLE;
          end else begin
            bit_cnt <= bit_cnt - CW'(1);
            if (bit_idx == BW'(DW - 1)) begin
              shreg   <= rd_data;
              sd      <= rd_data[DW-1];
              rd_ptr  <= rd_ptr + AW'(1);
              bit_idx <= '0;
            end else begin
              shreg   <= shreg << 1;
              sd      <= shreg[DW-2];
              bit_idx <= bit_idx + BW'(1);
            end
          end
        end

        default: st_q <= ST_IDLE;
      endcase
    end
  end

endmodule
